// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the round-robin AXI4 read-channel arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ArbState;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;

  always_comb begin
    dbl   = {req, req};
    rot   = dbl >> ptr;
    valid = 1'b0;
    idx   = '0;
    // Descending scan so the lowest rotated offset wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % int'(N));
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between NUM_MASTER requesters, one burst in flight at a time.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTER = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MIDX_WIDTH = $clog2(NUM_MASTER)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTER-1:0]          m_arvalid,
  output logic [NUM_MASTER-1:0]          m_arready,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTER*8-1:0]        m_arlen,
  input  logic [NUM_MASTER*3-1:0]        m_arsize,
  input  logic [NUM_MASTER*2-1:0]        m_arburst,
  input  logic [NUM_MASTER*ID_WIDTH-1:0] m_arid,
  output logic [NUM_MASTER-1:0]          m_rvalid,
  input  logic [NUM_MASTER-1:0]          m_rready,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic [ID_WIDTH-1:0]            m_rid,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic [7:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  output logic [1:0]                     s_arburst,
  output logic [ID_WIDTH-1:0]            s_arid,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic [1:0]                     s_rresp,
  input  logic                           s_rlast,
  input  logic [ID_WIDTH-1:0]            s_rid,
  output logic                           busy,
  output logic [MIDX_WIDTH-1:0]          grant_idx,
  output logic                           len_err
);

  ArbState               state;
  logic [MIDX_WIDTH-1:0] rr_ptr;
  logic [7:0]            beat_cnt;
  logic                  pick_valid;
  logic [MIDX_WIDTH-1:0] pick_idx;
  logic                  r_hs;

  rr_picker #(
    .N  (NUM_MASTER),
    .IW (MIDX_WIDTH)
  ) u_picker (
    .req   (m_arvalid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy      = (state != IDLE);
  assign s_arvalid = (state == ADDR);
  assign s_rready  = (state == DATA) && m_rready[grant_idx];
  assign r_hs      = (state == DATA) && s_rvalid && s_rready;

  // R payload is a zero-latency broadcast; only the valid is steered.
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_rid   = s_rid;

  always_comb begin
    m_arready = '0;
    if ((state == IDLE) && pick_valid && !rst) begin
      m_arready[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (state == DATA) begin
      m_rvalid[grant_idx] = s_rvalid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
      s_arid    <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            s_araddr  <= m_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_arlen   <= m_arlen[pick_idx*8 +: 8];
            s_arsize  <= m_arsize[pick_idx*3 +: 3];
            s_arburst <= m_arburst[pick_idx*2 +: 2];
            s_arid    <= m_arid[pick_idx*ID_WIDTH +: ID_WIDTH];
            grant_idx <= pick_idx;
            beat_cnt  <= m_arlen[pick_idx*8 +: 8];
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (s_rlast) begin
              state   <= IDLE;
              len_err <= (beat_cnt != 8'd0);
              // Explicit wrap keeps non-power-of-two NUM_MASTER in range.
              rr_ptr  <= (grant_idx == MIDX_WIDTH'(NUM_MASTER - 1)) ? '0 : grant_idx + 1'b1;
            end else if (beat_cnt == 8'd0) begin
              len_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (2-master and 3-master instances).
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared memory-side inputs
  logic        s_arready, s_rvalid, s_rlast;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [3:0]  s_rid;

  // Two-master instance
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [7:0]  m_arid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [3:0]  m_rid;
  logic        s_arvalid, s_rready, busy, len_err;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [3:0]  s_arid;
  logic [0:0]  grant_idx;

  // Three-master instance
  logic [2:0]  m_arvalid3, m_arready3, m_rvalid3, m_rready3;
  logic [95:0] m_araddr3;
  logic [23:0] m_arlen3;
  logic [8:0]  m_arsize3;
  logic [5:0]  m_arburst3;
  logic [11:0] m_arid3;
  logic [63:0] m_rdata3;
  logic [1:0]  m_rresp3;
  logic        m_rlast3;
  logic [3:0]  m_rid3;
  logic        s_arvalid3, s_rready3, busy3, len_err3;
  logic [31:0] s_araddr3;
  logic [7:0]  s_arlen3;
  logic [2:0]  s_arsize3;
  logic [1:0]  s_arburst3;
  logic [3:0]  s_arid3;
  logic [1:0]  grant_idx3;

  axi_rd_arbiter #(.NUM_MASTER(2)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .busy(busy), .grant_idx(grant_idx), .len_err(len_err)
  );

  axi_rd_arbiter #(.NUM_MASTER(3)) dut3 (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid3), .m_arready(m_arready3), .m_araddr(m_araddr3),
    .m_arlen(m_arlen3), .m_arsize(m_arsize3), .m_arburst(m_arburst3), .m_arid(m_arid3),
    .m_rvalid(m_rvalid3), .m_rready(m_rready3), .m_rdata(m_rdata3), .m_rresp(m_rresp3),
    .m_rlast(m_rlast3), .m_rid(m_rid3),
    .s_arvalid(s_arvalid3), .s_arready(s_arready), .s_araddr(s_araddr3), .s_arlen(s_arlen3),
    .s_arsize(s_arsize3), .s_arburst(s_arburst3), .s_arid(s_arid3),
    .s_rvalid(s_rvalid), .s_rready(s_rready3), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .busy(busy3), .grant_idx(grant_idx3), .len_err(len_err3)
  );

  task automatic set_req(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id);
    m_araddr[m*32 +: 32] = addr;
    m_arlen[m*8 +: 8]    = len;
    m_arsize[m*3 +: 3]   = 3'd3;
    m_arburst[m*2 +: 2]  = BURST_INCR;
    m_arid[m*4 +: 4]     = id;
  endtask

  task automatic set_req3(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id);
    m_araddr3[m*32 +: 32] = addr;
    m_arlen3[m*8 +: 8]    = len;
    m_arsize3[m*3 +: 3]   = 3'd2;
    m_arburst3[m*2 +: 2]  = BURST_WRAP;
    m_arid3[m*4 +: 4]     = id;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if ({s_arvalid, m_arready, m_rvalid, s_rready, len_err} !== 7'd0) begin
      failures++; $display("FAIL reset_handshakes got=%b exp=0",
                           {s_arvalid, m_arready, m_rvalid, s_rready, len_err});
    end
    checks++; if ({grant_idx, s_araddr, s_arlen, s_arsize, s_arburst, s_arid} !== 51'd0) begin
      failures++; $display("FAIL reset_ar_regs got=%h exp=0",
                           {grant_idx, s_araddr, s_arlen, s_arsize, s_arburst, s_arid});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (busy !== 1'b0 || m_arready !== 2'b00) begin
      failures++; $display("FAIL idle_no_req busy=%0h arready=%b exp 0/00", busy, m_arready);
    end
  endtask

  task automatic test_round_robin();
    m_rready = 2'b11;
    set_req(0, 32'h0000_0100, 8'd0, 4'h0);
    set_req(1, 32'h0000_0200, 8'd0, 4'h1);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      @(negedge clk); m_arvalid = 2'b11; s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      checks++; if (m_arready !== (2'b01 << g)) begin
        failures++; $display("FAIL rr_arready[%0d] got=%b exp=%b", i, m_arready, 2'b01 << g);
      end
      @(negedge clk); #1;
      checks++; if ({s_arvalid, s_arid, grant_idx} !== {1'b1, 4'(g), 1'(g)}) begin
        failures++; $display("FAIL rr_addr[%0d] got=%b/%h/%0d exp=1/%h/%0d",
                             i, s_arvalid, s_arid, grant_idx, g, g);
      end
      @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'(i); #1;
      checks++; if (m_rvalid !== (2'b01 << g)) begin
        failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, m_rvalid, 2'b01 << g);
      end
    end
    @(negedge clk); m_arvalid = 2'b00; s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 32'h8000_0000, 8'd3, 4'h5);
    m_rready = 2'b11;
    s_rid = 4'h5; s_rresp = RESP_OKAY;
    @(negedge clk); m_arvalid = 2'b01; s_arready = 1'b1; #1;
    checks++; if ({m_arready, s_arvalid} !== 3'b010) begin
      failures++; $display("FAIL single_cycle0 got=%b/%b exp=01/0", m_arready, s_arvalid);
    end
    @(negedge clk); m_arvalid = 2'b00; #1;
    checks++; if ({s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid, busy} !==
                  {1'b1, 32'h8000_0000, 8'd3, 3'd3, BURST_INCR, 4'h5, 1'b1}) begin
      failures++; $display("FAIL single_ar got=%b/%h/%0d/%0d/%b/%h/%b", s_arvalid, s_araddr,
                           s_arlen, s_arsize, s_arburst, s_arid, busy);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); s_rvalid = 1'b1; s_rdata = 64'(b) + 64'hA000; s_rlast = (b == 3); #1;
      checks++; if ({m_rvalid, s_rready} !== 3'b011 || m_rdata !== 64'(b) + 64'hA000) begin
        failures++; $display("FAIL single_beat[%0d] rvalid=%b rready=%b data=%h exp 01/1/%h",
                             b, m_rvalid, s_rready, m_rdata, 64'(b) + 64'hA000);
      end
    end
    checks++; if ({m_rlast, m_rid, m_rresp} !== {1'b1, 4'h5, RESP_OKAY}) begin
      failures++; $display("FAIL single_rfields got=%b/%h/%b exp=1/5/00", m_rlast, m_rid, m_rresp);
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    checks++; if ({busy, len_err} !== 2'b00) begin
      failures++; $display("FAIL single_done busy=%b len_err=%b exp 0/0", busy, len_err);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int k;
    int seen;
    pat = 4'b1010;
    k = 0;
    seen = 0;
    set_req(1, 32'h0000_1000, 8'd1, 4'h3);
    @(negedge clk); m_arvalid = 2'b10; s_arready = 1'b0; #1;
    checks++; if (m_arready !== 2'b10) begin
      failures++; $display("FAIL bp_arready got=%b exp=10", m_arready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); m_arvalid = 2'b00; set_req(1, 32'hDEAD_0000 + 32'(c), 8'd7, 4'hF);
      s_arready = (c == 5); #1;
      checks++; if ({s_arvalid, s_araddr, s_arlen, s_arid} !== {1'b1, 32'h1000, 8'd1, 4'h3}) begin
        failures++; $display("FAIL bp_ar_stable[%0d] got=%b/%h/%0d/%h exp=1/1000/1/3",
                             c, s_arvalid, s_araddr, s_arlen, s_arid);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'hB0 + 64'(k);
      s_rlast = (k == 1); m_rready = {pat[c], 1'b1}; #1;
      checks++; if ({s_rready, m_rvalid} !== {pat[c], 2'b10} || m_rdata !== 64'hB0 + 64'(k)) begin
        failures++; $display("FAIL bp_beat[%0d] rready=%b rvalid=%b data=%h exp %b/10/%h",
                             c, s_rready, m_rvalid, m_rdata, pat[c], 64'hB0 + 64'(k));
      end
      if (m_rvalid[1] && m_rready[1]) seen++;
      if (pat[c]) k++;
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b11; #1;
    checks++; if (seen != 2 || busy !== 1'b0 || len_err !== 1'b0) begin
      failures++; $display("FAIL bp_done beats=%0d busy=%b len_err=%b exp 2/0/0", seen, busy, len_err);
    end
  endtask

  task automatic test_len_mismatch();
    // Early rlast: arlen=1 but only one beat.
    set_req(0, 32'h0000_3000, 8'd1, 4'h2);
    @(negedge clk); m_arvalid = 2'b01; s_arready = 1'b1; #1;
    @(negedge clk); m_arvalid = 2'b00; #1;
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; #1;
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL short_pre got=%b exp=0", len_err); end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    checks++; if ({len_err, busy} !== 2'b10) begin
      failures++; $display("FAIL short_pulse len_err=%b busy=%b exp 1/0", len_err, busy);
    end
    @(negedge clk); #1;
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL short_clear got=%b exp=0", len_err); end
    // Late rlast: arlen=0 but two beats.
    set_req(0, 32'h0000_4000, 8'd0, 4'h2);
    @(negedge clk); m_arvalid = 2'b01; #1;
    @(negedge clk); m_arvalid = 2'b00; #1;
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b0; #1;
    @(negedge clk); s_rlast = 1'b1; #1;
    checks++; if ({len_err, busy, m_rvalid} !== 4'b1101) begin
      failures++; $display("FAIL long_pulse len_err=%b busy=%b rvalid=%b exp 1/1/01",
                           len_err, busy, m_rvalid);
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    checks++; if ({len_err, busy} !== 2'b00) begin
      failures++; $display("FAIL long_done len_err=%b busy=%b exp 0/0", len_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h0000_5000, 8'd3, 4'h6);
    @(negedge clk); m_arvalid = 2'b01; s_arready = 1'b1; #1;
    @(negedge clk); m_arvalid = 2'b00; #1;
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if ({busy, m_rvalid} !== 3'b101) begin
      failures++; $display("FAIL mid_pre busy=%b rvalid=%b exp 1/01", busy, m_rvalid);
    end
    rst = 1'b1; #1;
    checks++; if ({busy, m_rvalid, s_rready, s_arvalid, len_err, m_arready} !== 8'd0 ||
                  {grant_idx, s_araddr, s_arlen} !== 41'd0) begin
      failures++; $display("FAIL mid_reset busy=%b rv=%b rr=%b av=%b gi=%0d addr=%h len=%0d exp 0",
                           busy, m_rvalid, s_rready, s_arvalid, grant_idx, s_araddr, s_arlen);
    end
    @(negedge clk); rst = 1'b0; s_rvalid = 1'b0;
    set_req(0, 32'h0000_6000, 8'd0, 4'h0);
    set_req(1, 32'h0000_7000, 8'd0, 4'h1);
    // rr_ptr was 1 before the reset; a cleared pointer favours master 0.
    @(negedge clk); m_arvalid = 2'b11; #1;
    checks++; if (m_arready !== 2'b01) begin
      failures++; $display("FAIL mid_ptr_cleared got=%b exp=01", m_arready);
    end
    @(negedge clk); m_arvalid = 2'b00; #1;
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; #1;
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; m_arvalid = 2'b10; #1;
    checks++; if (m_arready !== 2'b10) begin
      failures++; $display("FAIL mid_m1_arready got=%b exp=10", m_arready);
    end
    @(negedge clk); m_arvalid = 2'b00; #1;
    checks++; if ({s_arvalid, s_araddr, grant_idx} !== {1'b1, 32'h7000, 1'b1}) begin
      failures++; $display("FAIL mid_m1_ar got=%b/%h/%0d exp=1/7000/1", s_arvalid, s_araddr, grant_idx);
    end
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; #1;
    checks++; if (m_rvalid !== 2'b10) begin
      failures++; $display("FAIL mid_m1_rvalid got=%b exp=10", m_rvalid);
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_m1_done busy=%b exp=0", busy); end
  endtask

  task automatic test_three_masters();
    m_rready3 = 3'b111;
    set_req3(1, 32'h0000_6100, 8'd0, 4'h1);
    set_req3(2, 32'h0000_6200, 8'd0, 4'h2);
    // Grant master 1 alone so the pointer moves to 2.
    @(negedge clk); m_arvalid3 = 3'b010; s_arready = 1'b1; #1;
    checks++; if (m_arready3 !== 3'b010) begin
      failures++; $display("FAIL n3_first got=%b exp=010", m_arready3);
    end
    @(negedge clk); m_arvalid3 = 3'b000; #1;
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h3131; #1;
    checks++; if (m_rvalid3 !== 3'b010 || m_rdata3 !== 64'h3131) begin
      failures++; $display("FAIL n3_first_r rvalid=%b data=%h exp 010/3131", m_rvalid3, m_rdata3);
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; m_arvalid3 = 3'b110; #1;
    checks++; if (m_arready3 !== 3'b100) begin
      failures++; $display("FAIL n3_ptr2 got=%b exp=100", m_arready3);
    end
    @(negedge clk); #1;
    checks++; if ({grant_idx3, s_arvalid3, s_araddr3, s_arlen3, s_arsize3, s_arburst3, s_arid3} !==
                  {2'd2, 1'b1, 32'h6200, 8'd0, 3'd2, BURST_WRAP, 4'h2}) begin
      failures++; $display("FAIL n3_m2_ar gi=%0d av=%b addr=%h id=%h exp 2/1/6200/2",
                           grant_idx3, s_arvalid3, s_araddr3, s_arid3);
    end
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h2; s_rresp = RESP_SLVERR; #1;
    checks++; if ({m_rvalid3, s_rready3, m_rlast3, m_rid3, m_rresp3} !==
                  {3'b100, 1'b1, 1'b1, 4'h2, RESP_SLVERR}) begin
      failures++; $display("FAIL n3_m2_r got=%b/%b/%b/%h/%b exp 100/1/1/2/10",
                           m_rvalid3, s_rready3, m_rlast3, m_rid3, m_rresp3);
    end
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = RESP_OKAY; #1;
    checks++; if (m_arready3 !== 3'b010) begin
      failures++; $display("FAIL n3_wrap got=%b exp=010", m_arready3);
    end
    @(negedge clk); m_arvalid3 = 3'b000; #1;
    checks++; if (grant_idx3 !== 2'd1) begin
      failures++; $display("FAIL n3_wrap_gi got=%0d exp=1", grant_idx3);
    end
    @(negedge clk); s_rvalid = 1'b1; s_rlast = 1'b1; #1;
    @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    checks++; if ({busy3, len_err3} !== 2'b00) begin
      failures++; $display("FAIL n3_done busy=%b len_err=%b exp 0/0", busy3, len_err3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_rid = '0;
    m_arvalid = '0; m_rready = '0; m_araddr = '0; m_arlen = '0;
    m_arsize = '0; m_arburst = '0; m_arid = '0;
    m_arvalid3 = '0; m_rready3 = '0; m_araddr3 = '0; m_arlen3 = '0;
    m_arsize3 = '0; m_arburst3 = '0; m_arid3 = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_len_mismatch();
    test_reset_mid();
    test_three_masters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
